// File: rtl/m_sync_debounce_pkg.sv
// Shared definitions for the synchroniser/debouncer: legal parameter ranges,
// the per-channel state encoding and the counter-width helper.
package m_sync_debounce_pkg;

  localparam int NUM_CH_MIN   = 1;
  localparam int NUM_CH_MAX   = 32;
  localparam int NUM_FF_MIN   = 2;
  localparam int NUM_FF_MAX   = 4;
  localparam int FILT_CYC_MIN = 1;
  localparam int FILT_CYC_MAX = 65535;

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } deb_state_e;

  // Ceiling log2; the debounce counter is clog2(FILT_CYC+1) bits wide.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((64'(1) << result) < 64'(value)) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/dflipflop.sv
// Library D flip-flop cell with asynchronous active-low reset to a fixed level.
module dflipflop #(
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RST_VAL;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/m_sync_debounce_ch.sv
// One channel: NUM_FF-stage synchroniser, FILT_CYC-sample stability filter
// and registered rise/fall pulses aligned with the output update.
module m_sync_debounce_ch
  import m_sync_debounce_pkg::*;
#(
  parameter int NUM_FF   = 3,
  parameter int FILT_CYC = 4,
  parameter bit RST_VAL  = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_data,
  output logic o_data,
  output logic o_rise,
  output logic o_fall
);

  localparam int              CNT_W    = clog2(FILT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYC - 1);

  logic [NUM_FF:0] sync_chain;
  logic            sync_val;

  deb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             data_q, data_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  assign sync_chain[0] = i_data;

  // Synchroniser stages must stay discrete flops: no merging, no retiming.
  for (genvar i = 0; i < NUM_FF; i++) begin : g_sync
    (* dont_touch = "true", ASYNC_REG = "TRUE" *)
    dflipflop #(
      .RST_VAL(RST_VAL)
    ) u_ff (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (sync_chain[i]),
      .q    (sync_chain[i+1])
    );
  end

  assign sync_val = sync_chain[NUM_FF];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      data_q  <= RST_VAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Any sample agreeing with the output restarts the filter; the output only
  // follows after FILT_CYC consecutive disagreeing samples.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (sync_val == data_q) begin
      state_d = ST_STABLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_STABLE: begin
          if (CNT_LAST == '0) begin
            data_d = sync_val;
            rise_d = sync_val;
            fall_d = ~sync_val;
          end else begin
            state_d = ST_PENDING;
            cnt_d   = CNT_W'(1);
          end
        end
        ST_PENDING: begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
            data_d  = sync_val;
            rise_d  = sync_val;
            fall_d  = ~sync_val;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign o_data = data_q;
  assign o_rise = rise_q;
  assign o_fall = fall_q;

endmodule

// File: rtl/m_sync_debounce.sv
// Multi-channel synchroniser and debouncer for asynchronous level inputs;
// each channel is an independent m_sync_debounce_ch instance.
module m_sync_debounce
  import m_sync_debounce_pkg::*;
#(
  parameter int NUM_CH   = 1,
  parameter int NUM_FF   = 3,
  parameter int FILT_CYC = 4,
  parameter bit RST_VAL  = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] i_data,
  output logic [NUM_CH-1:0] o_data,
  output logic [NUM_CH-1:0] o_rise,
  output logic [NUM_CH-1:0] o_fall
);

  if ((NUM_CH < NUM_CH_MIN) || (NUM_CH > NUM_CH_MAX)) begin : g_bad_num_ch
    $error("m_sync_debounce: NUM_CH=%0d outside %0d..%0d", NUM_CH, NUM_CH_MIN, NUM_CH_MAX);
  end

  if ((NUM_FF < NUM_FF_MIN) || (NUM_FF > NUM_FF_MAX)) begin : g_bad_num_ff
    $error("m_sync_debounce: NUM_FF=%0d outside %0d..%0d", NUM_FF, NUM_FF_MIN, NUM_FF_MAX);
  end

  if ((FILT_CYC < FILT_CYC_MIN) || (FILT_CYC > FILT_CYC_MAX)) begin : g_bad_filt_cyc
    $error("m_sync_debounce: FILT_CYC=%0d outside %0d..%0d", FILT_CYC, FILT_CYC_MIN, FILT_CYC_MAX);
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    m_sync_debounce_ch #(
      .NUM_FF  (NUM_FF),
      .FILT_CYC(FILT_CYC),
      .RST_VAL (RST_VAL)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .i_data(i_data[ch]),
      .o_data(o_data[ch]),
      .o_rise(o_rise[ch]),
      .o_fall(o_fall[ch])
    );
  end

endmodule

// File: tb/tb_m_sync_debounce.sv
// Bench for m_sync_debounce: a vector table, directed corner sequences and a
// randomized run against a stability-window reference model.
module tb_m_sync_debounce;

  localparam int NFF  = 3;
  localparam int HIST = 64;

  typedef struct packed {
    logic       rst;
    logic [1:0] din;
    logic [1:0] exp_d;
    logic [1:0] exp_r;
    logic [1:0] exp_f;
  } vec_t;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b1;
  logic [1:0] i_data    = 2'b00;
  logic [1:0] i_data_nf = 2'b00;
  logic [1:0] o_data, o_rise, o_fall;
  logic [1:0] nf_data, nf_rise, nf_fall;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  m_sync_debounce #(
    .NUM_CH(2), .NUM_FF(NFF), .FILT_CYC(4), .RST_VAL(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_data(i_data),
    .o_data(o_data), .o_rise(o_rise), .o_fall(o_fall)
  );

  m_sync_debounce #(
    .NUM_CH(2), .NUM_FF(NFF), .FILT_CYC(1), .RST_VAL(1'b0)
  ) dut_nf (
    .clk(clk), .rst_n(rst_n), .i_data(i_data_nf),
    .o_data(nf_data), .o_rise(nf_rise), .o_fall(nf_fall)
  );

  // Reference: the synchronised value seen at edge n is the input sampled
  // NFF edges earlier; an output bit follows it once that value has been
  // held for filt consecutive samples.
  int         filt[2] = '{4, 1};
  logic [1:0] smp[2][HIST];
  int         m_n[2];
  int         m_run[2][2];
  logic [1:0] m_prev[2], m_out[2], m_rise[2], m_fall[2];
  logic [1:0] s_seen;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        m_n[d] = 0; m_prev[d] = 2'b00; m_out[d] = 2'b00;
        m_rise[d] = 2'b00; m_fall[d] = 2'b00;
        m_run[d][0] = 0; m_run[d][1] = 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        m_n[d] = m_n[d] + 1;
        smp[d][m_n[d] % HIST] = (d == 0) ? i_data : i_data_nf;
        s_seen = (m_n[d] > NFF) ? smp[d][(m_n[d] - NFF) % HIST] : 2'b00;
        m_rise[d] = 2'b00;
        m_fall[d] = 2'b00;
        for (int c = 0; c < 2; c++) begin
          m_run[d][c] = (s_seen[c] == m_prev[d][c]) ? m_run[d][c] + 1 : 1;
          if ((s_seen[c] != m_out[d][c]) && (m_run[d][c] >= filt[d])) begin
            m_out[d][c] = s_seen[c];
            if (s_seen[c]) m_rise[d][c] = 1'b1;
            else           m_fall[d][c] = 1'b1;
          end
        end
        m_prev[d] = s_seen;
      end
    end
  end

  task automatic addVec(input logic r, input logic [1:0] d, input logic [1:0] ed,
                        input logic [1:0] er, input logic [1:0] ef);
    vec_t v;
    v.rst = r; v.din = d; v.exp_d = ed; v.exp_r = er; v.exp_f = ef;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic r, input logic [1:0] d, input logic [1:0] dnf);
    rst_n     = r;
    i_data    = d;
    i_data_nf = dnf;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input bit nf, input logic [1:0] ed,
                             input logic [1:0] er, input logic [1:0] ef);
    logic [5:0] act;
    logic [5:0] req;
    act = nf ? {nf_data, nf_rise, nf_fall} : {o_data, o_rise, o_fall};
    req = {ed, er, ef};
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s @%0t: data/rise/fall got %b/%b/%b required %b/%b/%b",
               name, $time, act[5:4], act[3:2], act[1:0], req[5:4], req[3:2], req[1:0]);
    end
  endtask

  task automatic resetTo(input logic [1:0] d, input logic [1:0] dnf);
    repeat (2) applyStimulus(1'b0, d, dnf);
    repeat (10) applyStimulus(1'b1, d, dnf);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [1:0] rd, rnf, din;
    logic       r;
    int         b;

    #1 rst_n = 1'b0;
    @(negedge clk);

    // Reset with inputs high, then release; clean rise and fall on ch0.
    repeat (2) addVec(1'b0, 2'b11, 2'b00, 2'b00, 2'b00);
    repeat (6) addVec(1'b1, 2'b11, 2'b00, 2'b00, 2'b00);
    addVec(1'b1, 2'b11, 2'b11, 2'b11, 2'b00);
    repeat (2) addVec(1'b1, 2'b11, 2'b11, 2'b00, 2'b00);
    repeat (2) addVec(1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
    repeat (6) addVec(1'b1, 2'b01, 2'b00, 2'b00, 2'b00);
    addVec(1'b1, 2'b01, 2'b01, 2'b01, 2'b00);
    repeat (2) addVec(1'b1, 2'b01, 2'b01, 2'b00, 2'b00);
    repeat (6) addVec(1'b1, 2'b00, 2'b01, 2'b00, 2'b00);
    addVec(1'b1, 2'b00, 2'b00, 2'b00, 2'b01);
    addVec(1'b1, 2'b00, 2'b00, 2'b00, 2'b00);

    foreach (vecs[k]) begin
      applyStimulus(vecs[k].rst, vecs[k].din, 2'b00);
      checkOutput($sformatf("vec%0d", k), 1'b0, vecs[k].exp_d, vecs[k].exp_r, vecs[k].exp_f);
    end

    // 3-cycle glitch on ch1 is swallowed.
    resetTo(2'b00, 2'b00);
    for (int k = 1; k <= 13; k++) begin
      applyStimulus(1'b1, (k <= 3) ? 2'b10 : 2'b00, 2'b00);
      checkOutput("glitch3", 1'b0, 2'b00, 2'b00, 2'b00);
    end

    // A pulse exactly FILT_CYC wide passes: rise at edge 7, fall at edge 11.
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(1'b1, (k <= 4) ? 2'b10 : 2'b00, 2'b00);
      if (k < 7)       checkOutput("pulse4", 1'b0, 2'b00, 2'b00, 2'b00);
      else if (k == 7) checkOutput("pulse4", 1'b0, 2'b10, 2'b10, 2'b00);
      else if (k < 11) checkOutput("pulse4", 1'b0, 2'b10, 2'b00, 2'b00);
      else if (k == 11) checkOutput("pulse4", 1'b0, 2'b00, 2'b00, 2'b10);
      else             checkOutput("pulse4", 1'b0, 2'b00, 2'b00, 2'b00);
    end

    // Opposite simultaneous changes on both channels.
    resetTo(2'b01, 2'b00);
    checkOutput("simul_pre", 1'b0, 2'b01, 2'b00, 2'b00);
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1'b1, 2'b10, 2'b00);
      if (k < 7)       checkOutput("simul", 1'b0, 2'b01, 2'b00, 2'b00);
      else if (k == 7) checkOutput("simul", 1'b0, 2'b10, 2'b10, 2'b01);
      else             checkOutput("simul", 1'b0, 2'b10, 2'b00, 2'b00);
    end

    // Reset while a rise is pending discards it without a pulse.
    resetTo(2'b00, 2'b00);
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b1, 2'b11, 2'b00);
      checkOutput("midrst_pend", 1'b0, 2'b00, 2'b00, 2'b00);
    end
    applyStimulus(1'b0, 2'b11, 2'b00);
    checkOutput("midrst_hold", 1'b0, 2'b00, 2'b00, 2'b00);
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1'b1, 2'b11, 2'b00);
      if (k < 7)       checkOutput("midrst_after", 1'b0, 2'b00, 2'b00, 2'b00);
      else if (k == 7) checkOutput("midrst_after", 1'b0, 2'b11, 2'b11, 2'b00);
      else             checkOutput("midrst_after", 1'b0, 2'b11, 2'b00, 2'b00);
    end

    // FILT_CYC=1: step lands at edge 4 and a single-cycle pulse propagates.
    resetTo(2'b00, 2'b00);
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(1'b1, 2'b00, 2'b01);
      if (k < 4)       checkOutput("nf_step", 1'b1, 2'b00, 2'b00, 2'b00);
      else if (k == 4) checkOutput("nf_step", 1'b1, 2'b01, 2'b01, 2'b00);
      else             checkOutput("nf_step", 1'b1, 2'b01, 2'b00, 2'b00);
    end
    for (int k = 1; k <= 7; k++) begin
      applyStimulus(1'b1, 2'b00, (k == 1) ? 2'b11 : 2'b01);
      if (k < 4)       checkOutput("nf_pulse", 1'b1, 2'b01, 2'b00, 2'b00);
      else if (k == 4) checkOutput("nf_pulse", 1'b1, 2'b11, 2'b10, 2'b00);
      else if (k == 5) checkOutput("nf_pulse", 1'b1, 2'b01, 2'b00, 2'b10);
      else             checkOutput("nf_pulse", 1'b1, 2'b01, 2'b00, 2'b00);
    end

    // Randomized run, both instances against the reference model.
    rd  = i_data;
    rnf = i_data_nf;
    for (int k = 0; k < 2500; k++) begin
      if ($urandom_range(0, 4) == 0) begin
        b  = $urandom_range(0, 1);
        rd = rd ^ (2'b01 << b);
      end
      if ($urandom_range(0, 2) == 0) begin
        b   = $urandom_range(0, 1);
        rnf = rnf ^ (2'b01 << b);
      end
      r   = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      din = rd;
      applyStimulus(r, din, rnf);
      checkOutput("rand_f4", 1'b0, m_out[0], m_rise[0], m_fall[0]);
      checkOutput("rand_f1", 1'b1, m_out[1], m_rise[1], m_fall[1]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
